// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types and constants for the ID/EX pipeline stage
package riscv_pipe_pkg;
  typedef logic [4:0] reg_idx_t;
  typedef logic [31:0] word_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  typedef struct packed {
    logic     valid;
    word_t    pc;
    word_t    rs1_val;
    word_t    rs2_val;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    word_t    imm;
    logic     mem_read;
    logic     ru_write;
  } id_ex_t;
  localparam id_ex_t ID_EX_BUBBLE = '0;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: selects x0, same-cycle write-back data, or register-file data for one operand
module operand_bypass
  import riscv_pipe_pkg::*;
(
  input  reg_idx_t idx_i,
  input  word_t    rf_data_i,
  input  reg_idx_t wb_rd_i,
  input  logic     wb_we_i,
  input  word_t    wb_data_i,
  output word_t    val_o
);
  assign val_o = (idx_i == REG_ZERO) ? '0 :
                 (wb_we_i && wb_rd_i == idx_i) ? wb_data_i : rf_data_i;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use stall and bubble counting
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  word_t             id_pc,
  input  reg_idx_t          id_rs1,
  input  reg_idx_t          id_rs2,
  input  reg_idx_t          id_rd,
  input  word_t             id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_mem_read,
  input  logic              id_RUwrite,
  input  word_t             RU1,
  input  word_t             RU2,
  input  reg_idx_t          wb_rd,
  input  logic              wb_RUwrite,
  input  word_t             wb_RUdw,
  input  logic              ex_flush,
  input  logic              ex_hold,
  output logic              stall_if_id,
  output logic              ex_valid,
  output word_t             ex_pc,
  output word_t             ex_rs1_val,
  output word_t             ex_rs2_val,
  output reg_idx_t          ex_rs1,
  output reg_idx_t          ex_rs2,
  output reg_idx_t          ex_rd,
  output word_t             ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_RUwrite,
  output logic [CNT_W-1:0]  bubble_cnt
);
  id_ex_t ex_q, ex_d, cap;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t op1, op2;
  logic lu, bubble;
  operand_bypass u_op1 (
    .idx_i(id_rs1), .rf_data_i(RU1), .wb_rd_i(wb_rd), .wb_we_i(wb_RUwrite), .wb_data_i(wb_RUdw), .val_o(op1)
  );
  operand_bypass u_op2 (
    .idx_i(id_rs2), .rf_data_i(RU2), .wb_rd_i(wb_rd), .wb_we_i(wb_RUwrite), .wb_data_i(wb_RUdw), .val_o(op2)
  );
  assign lu = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != REG_ZERO) &
              ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));
  assign stall_if_id = (lu & ~ex_flush) | ex_hold;
  // a flush always bubbles; a load-use bubbles only when the slot is not frozen
  assign bubble = ex_flush | (~ex_hold & lu);
  assign cap = '{valid: id_valid, pc: id_pc, rs1_val: op1, rs2_val: op2, rs1: id_rs1, rs2: id_rs2,
                 rd: id_rd, imm: id_imm, mem_read: id_valid & id_mem_read, ru_write: id_valid & id_RUwrite};
  assign ex_d = bubble ? ID_EX_BUBBLE : ex_hold ? ex_q : cap;
  assign ctrl_d = bubble ? '0 : ex_hold ? ctrl_q : id_ctrl;
  assign cnt_d = (bubble && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // ID/EX register and saturating bubble counter; reset empties the EX slot at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= ID_EX_BUBBLE;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end
  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_val  = ex_q.rs1_val;
  assign ex_rs2_val  = ex_q.rs2_val;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_imm      = ex_q.imm;
  assign ex_ctrl     = ctrl_q;
  assign ex_mem_read = ex_q.mem_read;
  assign ex_RUwrite  = ex_q.ru_write;
  assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage with a 4-bit bubble counter
module tb_id_ex_stage;
  logic clk = 0, rst = 1;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_mem_read, id_RUwrite, wb_RUwrite, ex_flush, ex_hold;
  logic [31:0] id_pc, id_imm, RU1, RU2, wb_RUdw;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [15:0] id_ctrl;
  logic stall_if_id, ex_valid, ex_mem_read, ex_RUwrite;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_ctrl;
  logic [3:0] bubble_cnt;
  typedef struct {
    int cyc;
    logic v, mr, rw;
    logic [31:0] pc, a, b, imm;
    logic [4:0] rd;
    logic [15:0] ctrl;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t last, m;
  int cyc = 0, errs = 0, checks = 0;
  id_ex_stage #(.CTRL_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_mem_read(id_mem_read), .id_RUwrite(id_RUwrite), .RU1(RU1),
    .RU2(RU2), .wb_rd(wb_rd), .wb_RUwrite(wb_RUwrite), .wb_RUdw(wb_RUdw), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_RUwrite(ex_RUwrite), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, want, cyc);
    end
  endfunction
  // monitor: compare EX outputs against every expectation due at this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      chk("ex_valid", ex_valid, m.v);
      chk("bubble_cnt", bubble_cnt, m.cnt);
      chk("ex_mem_read", ex_mem_read, m.mr);
      chk("ex_RUwrite", ex_RUwrite, m.rw);
      if (m.v) begin
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rs1_val", ex_rs1_val, m.a);
        chk("ex_rs2_val", ex_rs2_val, m.b);
        chk("ex_rd", ex_rd, m.rd);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_ctrl", ex_ctrl, m.ctrl);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    exp_t e;
    e.cyc = cyc + 1; e.v = v; e.pc = id_pc; e.a = a; e.b = b; e.imm = id_imm; e.rd = id_rd;
    e.ctrl = id_ctrl; e.mr = v & id_mem_read; e.rw = v & id_RUwrite; e.cnt = c;
    q.push_back(e);
    last = e;
  endtask
  task automatic push_hold();
    exp_t e;
    e = last;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                        input logic rw, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_uses_rs1 = u1;
    id_uses_rs2 = u2; id_mem_read = mr; id_RUwrite = rw; RU1 = d1; RU2 = d2;
    id_imm = pc ^ 32'hFFFF_0000; id_ctrl = pc[15:0] + 16'h1000;
  endtask
  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_rd = 0; wb_RUwrite = 0; wb_RUdw = 0; ex_flush = 0; ex_hold = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_valid", ex_valid, 0);
    chk("reset_cnt", bubble_cnt, 0);
    // write-back bypass on rs1
    set_id(1, 32'h100, 5, 6, 3, 1, 1, 0, 1, 32'h11, 32'h22);
    wb_rd = 5; wb_RUwrite = 1; wb_RUdw = 32'hDEADBEEF;
    #1 chk("stall_idle", stall_if_id, 0);
    push(1, 32'hDEADBEEF, 32'h22, 0);
    tick();
    // x0 never bypasses even when write-back targets x0
    set_id(1, 32'h104, 0, 6, 9, 1, 1, 0, 1, 32'h55, 32'h22);
    wb_rd = 0; wb_RUdw = 32'hCAFEF00D;
    #1 push(1, 0, 32'h22, 0);
    tick();
    // load into x7
    set_id(1, 32'h108, 2, 0, 7, 1, 0, 1, 1, 32'h1000, 32'h99);
    wb_RUwrite = 0;
    #1 push(1, 32'h1000, 0, 0);
    tick();
    // dependent add stalls one cycle, then is captured
    set_id(1, 32'h10C, 1, 7, 8, 1, 1, 0, 1, 32'h1, 32'h2);
    #1 chk("stall_lu", stall_if_id, 1);
    push(0, 0, 0, 1);
    tick();
    #1 chk("stall_lu_clear", stall_if_id, 0);
    push(1, 32'h1, 32'h2, 1);
    tick();
    // same dependency but rs2 unused: no stall
    set_id(1, 32'h110, 2, 0, 7, 1, 0, 1, 1, 32'h2000, 0);
    #1 push(1, 32'h2000, 0, 1);
    tick();
    set_id(1, 32'h114, 1, 7, 8, 1, 0, 0, 1, 32'h1, 32'h77);
    #1 chk("stall_unused_rs2", stall_if_id, 0);
    push(1, 32'h1, 32'h77, 1);
    tick();
    // load-use plus flush plus hold: flush wins, hold drives the stall
    set_id(1, 32'h118, 2, 0, 7, 1, 0, 1, 1, 32'h3000, 0);
    #1 push(1, 32'h3000, 0, 1);
    tick();
    set_id(1, 32'h11C, 1, 7, 8, 1, 1, 0, 1, 32'h1, 32'h2);
    ex_flush = 1; ex_hold = 1;
    #1 chk("stall_flush_hold", stall_if_id, 1);
    push(0, 0, 0, 2);
    tick();
    ex_flush = 0; ex_hold = 0;
    // hold freezes the slot for three cycles while ID changes
    set_id(1, 32'h120, 3, 4, 10, 1, 1, 0, 1, 32'h33, 32'h44);
    #1 chk("stall_none", stall_if_id, 0);
    push(1, 32'h33, 32'h44, 2);
    tick();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h200 + i * 4, 5'(i + 1), 5'(i + 2), 7, 1, 1, 1, 1, i, i);
      #1 chk("stall_hold", stall_if_id, 1);
      push_hold();
      tick();
    end
    ex_hold = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 push(0, 0, 0, 2);
    tick();
    // twenty flushes saturate the 4-bit counter at 15
    ex_flush = 1;
    for (int i = 0; i < 20; i++) begin
      #1 push(0, 0, 0, (i + 3 > 15) ? 4'd15 : 4'(i + 3));
      tick();
    end
    ex_flush = 0;
    #1 push(0, 0, 0, 15);
    tick();
    // asynchronous reset mid-stream with a valid instruction in EX
    set_id(1, 32'h300, 3, 4, 5, 1, 1, 0, 1, 32'hABC, 32'hDEF);
    #1 push(1, 32'hABC, 32'hDEF, 15);
    tick();
    @(negedge clk);
    #1 rst = 1;
    #1 chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_cnt", bubble_cnt, 0);
    chk("async_rst_pc", ex_pc, 0);
    chk("async_rst_rs1_val", ex_rs1_val, 0);
    chk("async_rst_RUwrite", ex_RUwrite, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Captures the two register-file read ports (RU1/RU2) together with decoded fields into the ID/EX pipeline register.
- Bypasses a same-cycle write-back value that the register file cannot yet return.
- Detects load-use hazards and requests a front-end stall.
- Inserts bubbles on stall or branch flush.

Parameters:
CTRL_W, 16, width of the packed decoded-control bundle passed through to EX
CNT_W, 32, width of the saturating bubble performance counter

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  32  PC of the ID instruction
id_rs1  input  5  source register 1 index (also drives register-file rs1)
id_rs2  input  5  source register 2 index (also drives register-file rs2)
id_rd  input  5  destination index
id_imm  input  32  sign-extended immediate
id_ctrl  input  CTRL_W  decoded control bundle
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_mem_read  input  1  instruction is a load
id_RUwrite  input  1  instruction writes rd
RU1  input  32  register-file read data for id_rs1
RU2  input  32  register-file read data for id_rs2
wb_rd  input  5  write-back destination (same signal driving register-file rd)
wb_RUwrite  input  1  write-back enable
wb_RUdw  input  32  write-back data
ex_flush  input  1  branch/jump taken in EX; squash ID instruction
ex_hold  input  1  downstream stall; freeze ID/EX register
stall_if_id  output  1  combinational: freeze PC and IF/ID
ex_valid  output  1  EX slot holds a real instruction
ex_pc  output  32  registered id_pc
ex_rs1_val  output  32  registered operand 1
ex_rs2_val  output  32  registered operand 2
ex_rs1  output  5  registered id_rs1
ex_rs2  output  5  registered id_rs2
ex_rd  output  5  registered id_rd
ex_imm  output  32  registered id_imm
ex_ctrl  output  CTRL_W  registered id_ctrl
ex_mem_read  output  1  registered id_mem_read, gated by valid
ex_RUwrite  output  1  registered id_RUwrite, gated by valid
bubble_cnt  output  CNT_W  count of bubbles inserted

Behaviour:
Reset:
- Asynchronous, active-high; all registered outputs go to 0, including ex_valid and bubble_cnt.
- Reset asserted mid-operation discards the EX slot immediately.

Operand selection (combinational, evaluated on the ID side):
- op1 = 0 if id_rs1==0.
- Else op1 = wb_RUdw if wb_RUwrite and wb_rd==id_rs1.
- Else op1 = RU1.
- op2 is formed the same way from id_rs2 and RU2.
- x0 never bypasses, even when wb_rd==0 with wb_RUwrite=1.

Load-use hazard:
- lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

stall_if_id:
- stall_if_id = (lu & ~ex_flush) | ex_hold.

Per rising edge, in priority order:
1. ex_flush: load a bubble (ex_valid=0, ex_mem_read=0, ex_RUwrite=0; other fields don't-care, implementation drives 0). Flush beats hold.
2. ex_hold: all registers keep their value. No bubble is counted.
3. lu: load a bubble; the ID instruction is re-presented next cycle.
4. Otherwise: capture op1/op2 and all id_* fields. ex_valid=id_valid; ex_mem_read and ex_RUwrite are ANDed with id_valid.

Latency and counter:
- Latency is one cycle from ID to EX.
- A load-use stall costs exactly one bubble; on the next cycle ex_mem_read=0, so lu deasserts.
- bubble_cnt increments on every bubble from case 1 or 3, saturates at all-ones and never wraps.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - typedef reg_idx_t (5-bit) and word_t (32-bit);
  - constant REG_ZERO=5'd0;
  - struct id_ex_t bundling the registered fields, so bubble insertion is a single constant assignment (ID_EX_BUBBLE).
- One sub-module, operand_bypass: a pure combinational index/enable/data mux, instantiated twice for rs1 and rs2.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 -> all outputs 0 immediately, before any clock edge; bubble_cnt=0.
- WB bypass: id_rs1=5, RU1=0x11, wb_rd=5, wb_RUwrite=1, wb_RUdw=0xDEADBEEF -> next cycle ex_rs1_val=0xDEADBEEF. Repeat with wb_rd=0, id_rs1=0 -> ex_rs1_val=0.
- Load-use: EX holds a load with ex_rd=7; ID has add with id_rs2=7, id_uses_rs2=1 -> stall_if_id=1; next cycle ex_valid=0; following cycle add is captured; bubble_cnt=1. Same case with id_uses_rs2=0 -> no stall.
- Flush beats stall and hold: load-use condition plus ex_flush=1 plus ex_hold=1 -> stall_if_id=1 (driven by hold), ex_valid=0 next edge, bubble_cnt increments.
- Hold: ex_hold=1 for 3 cycles with changing id_* inputs -> ex_* outputs unchanged, bubble_cnt unchanged.
- Saturation: preload via CNT_W=4 build, force 20 flushes -> bubble_cnt stops at 15.
